// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width default and 4-bit opcode map
package alu_pkg;
  localparam int WIDTH = 8;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_NAND = 4'h8;
  localparam logic [3:0] OP_NOR  = 4'h9;
  localparam logic [3:0] OP_XNOR = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_ROL  = 4'hD;
  localparam logic [3:0] OP_ROR  = 4'hE;
  localparam logic [3:0] OP_MUL  = 4'hF;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational result and carry; ports i_a/i_b operands, i_sl opcode, o_y result, o_c carry
module alu_core import alu_pkg::*; #(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_sl,
  output logic [W-1:0] o_y,
  output logic         o_c
);
  logic [2*W-1:0] w_prod;
  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  always_comb begin
    o_y = '0;
    o_c = 1'b0;
    case (i_sl)
      OP_ADD:  {o_c, o_y} = {1'b0, i_a} + {1'b0, i_b};
      OP_SUB:  {o_c, o_y} = {1'b0, i_a} - {1'b0, i_b};
      OP_INC:  {o_c, o_y} = {1'b0, i_a} + (W+1)'(1);
      OP_DEC:  {o_c, o_y} = {1'b0, i_a} - (W+1)'(1);
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NOT:  o_y = ~i_a;
      OP_NAND: o_y = ~(i_a & i_b);
      OP_NOR:  o_y = ~(i_a | i_b);
      OP_XNOR: o_y = ~(i_a ^ i_b);
      OP_SHL:  {o_c, o_y} = {i_a, 1'b0};
      OP_SHR:  {o_y, o_c} = {1'b0, i_a};
      OP_ROL:  {o_c, o_y} = {i_a[W-1], i_a[W-2:0], i_a[W-1]};
      OP_ROR:  {o_y, o_c} = {i_a[0], i_a[W-1:1], i_a[0]};
      OP_MUL:  {o_c, o_y} = {|w_prod[2*W-1:W], w_prod[W-1:0]};
    endcase
  end
endmodule

// File: rtl/alu.sv
// alu: registered ALU; A/B operands, SL opcode -> Su result, C carry, Z zero, S sign, P even parity (1-cycle latency)
module alu #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       SL,
  output logic [WIDTH-1:0] Su,
  output logic             C,
  output logic             Z,
  output logic             S,
  output logic             P
);
  logic [WIDTH-1:0] w_y;
  logic             w_c;
  alu_core #(.W(WIDTH)) u_core (.i_a(A), .i_b(B), .i_sl(SL), .o_y(w_y), .o_c(w_c));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Su <= '0;
      C  <= 1'b0;
      Z  <= 1'b0;
      S  <= 1'b0;
      P  <= 1'b0;
    end else begin
      Su <= w_y;
      C  <= w_c;
      Z  <= ~|w_y;
      S  <= w_y[WIDTH-1];
      P  <= ~^w_y;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven, random and back-to-back checks of alu against an arithmetic reference model
module tb_alu;
  import alu_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [3:0] SL = '0;
  logic [7:0] Su;
  logic       C, Z, S, P;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic [7:0] a, b;
    logic [3:0] sl;
    logic [7:0] su;
    logic       c, z, s, p;
  } vec_t;
  vec_t tbl[$];
  alu dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .SL(SL), .Su(Su), .C(C), .Z(Z), .S(S), .P(P));
  always #5 clk = ~clk;
  function automatic logic [11:0] model(int a, int b, int op);
    int r, c;
    logic [7:0] r8;
    c = 0;
    case (op)
      0:  begin r = a + b; c = int'(r > 255); end
      1:  begin r = a - b + 256; c = int'(a < b); end
      2:  begin r = a + 1; c = int'(r > 255); end
      3:  begin r = a - 1 + 256; c = int'(a == 0); end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = 255 - a;
      8:  r = 255 - (a & b);
      9:  r = 255 - (a | b);
      10: r = 255 - (a ^ b);
      11: begin r = a * 2; c = int'(a >= 128); end
      12: begin r = a / 2; c = a % 2; end
      13: begin r = (a * 2) % 256 + a / 128; c = int'(a >= 128); end
      14: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      default: begin r = a * b; c = int'(r > 255); end
    endcase
    r  = r % 256;
    r8 = 8'(r);
    return {r8, c[0], r == 0, r >= 128, ($countones(r8) % 2) == 0};
  endfunction
  task automatic check(string name, logic [11:0] exp);
    vectors++;
    if ({Su, C, Z, S, P} !== exp) begin
      miscompares++;
      $display("FAIL %s: got Su=%h C=%b Z=%b S=%b P=%b, expected Su=%h C=%b Z=%b S=%b P=%b",
               name, Su, C, Z, S, P, exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask
  task automatic run(logic [7:0] a, logic [7:0] b, logic [3:0] sl);
    A = a; B = b; SL = sl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl.push_back('{8'h93, 8'h02, OP_ADD,  8'h95, 0, 0, 1, 1});
    tbl.push_back('{8'h93, 8'h02, OP_SUB,  8'h91, 0, 0, 1, 0});
    tbl.push_back('{8'h93, 8'h02, OP_INC,  8'h94, 0, 0, 1, 0});
    tbl.push_back('{8'h93, 8'h02, OP_DEC,  8'h92, 0, 0, 1, 0});
    tbl.push_back('{8'h02, 8'h93, OP_SUB,  8'h6F, 1, 0, 0, 1});
    tbl.push_back('{8'h00, 8'h02, OP_DEC,  8'hFF, 1, 0, 1, 1});
    tbl.push_back('{8'h93, 8'h02, OP_AND,  8'h02, 0, 0, 0, 0});
    tbl.push_back('{8'h93, 8'h02, OP_OR,   8'h93, 0, 0, 1, 1});
    tbl.push_back('{8'h93, 8'h02, OP_XOR,  8'h91, 0, 0, 1, 0});
    tbl.push_back('{8'h93, 8'h02, OP_NOT,  8'h6C, 0, 0, 0, 1});
    tbl.push_back('{8'h93, 8'h02, OP_NAND, 8'hFD, 0, 0, 1, 0});
    tbl.push_back('{8'h93, 8'h02, OP_NOR,  8'h6C, 0, 0, 0, 1});
    tbl.push_back('{8'h93, 8'h02, OP_XNOR, 8'h6E, 0, 0, 0, 0});
    tbl.push_back('{8'h93, 8'h02, OP_SHL,  8'h26, 1, 0, 0, 0});
    tbl.push_back('{8'h93, 8'h02, OP_SHR,  8'h49, 1, 0, 0, 0});
    tbl.push_back('{8'h93, 8'h02, OP_ROL,  8'h27, 1, 0, 0, 1});
    tbl.push_back('{8'h93, 8'h02, OP_ROR,  8'hC9, 1, 0, 1, 1});
    tbl.push_back('{8'hFF, 8'h01, OP_ADD,  8'h00, 1, 1, 0, 1});
    tbl.push_back('{8'hFF, 8'h00, OP_INC,  8'h00, 1, 1, 0, 1});
    tbl.push_back('{8'h93, 8'h02, OP_MUL,  8'h26, 1, 0, 0, 0});
    tbl.push_back('{8'h0F, 8'h0F, OP_MUL,  8'hE1, 0, 0, 1, 1});
    #12;
    check("reset_state", 12'h000);
    rst_n = 1'b1;
    run(8'hFF, 8'hFF, OP_ADD);
    check("pre_reset_add", {8'hFE, 4'b1010});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h93, 8'h02, OP_ADD);
    check("post_reset_add", {8'h95, 4'b0011});
    foreach (tbl[i]) begin
      run(tbl[i].a, tbl[i].b, tbl[i].sl);
      check($sformatf("table[%0d] op=%h", i, tbl[i].sl),
            {tbl[i].su, tbl[i].c, tbl[i].z, tbl[i].s, tbl[i].p});
    end
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, b;
      logic [3:0] op;
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 4'($urandom);
      if (i % 10 == 0) b = 8'h00;
      if (i % 10 == 1) a = 8'hFF;
      run(a, b, op);
      check($sformatf("rand a=%h b=%h op=%h", a, b, op), model(int'(a), int'(b), int'(op)));
    end
    A = 8'h93; B = 8'h02;
    for (int i = 0; i < 16; i++) begin
      SL = 4'(i);
      if (i > 0) begin
        #2;
        check($sformatf("hold op=%h", i - 1), model(8'h93, 8'h02, i - 1));
      end
      @(posedge clk);
      #1;
      check($sformatf("b2b op=%h", i), model(8'h93, 8'h02, i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
